mul_div_arbiter: RTL
====================

MUL_DIV_ARBITER -- requirements
Module: mul_div_arbiter

Interface
REQ-001 Parameter WIDTH, 32, operand/result width (fixed-point word shared with the step datapath).
REQ-002 Parameter NREQ, 3, number of requesters (0 = step control, 1 = integrator, 2 = error accumulator); fixed at 3.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req  in  NREQ  per-requester request level; held high until that requester's done pulse.
REQ-006 op  in  NREQ  per-requester operation: 0 = multiply, 1 = divide.
REQ-007 a_flat, b_flat  in  NREQ*WIDTH each  operand pairs; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 mul_start, div_start  out  1 each  one-cycle start pulses to the shared multiplier/divider.
REQ-009 unit_a, unit_b  out  WIDTH each  operands to both units; unit_a is the dividend for divide.
REQ-010 mul_done, div_done  in  1 each  completion pulses from the units.
REQ-011 mul_result, div_result  in  WIDTH each  unit outputs; valid in the cycle of the matching done pulse.
REQ-012 gnt  out  NREQ  one-hot owner of the units; all-zero when idle.
REQ-013 done  out  NREQ  one-hot, one-cycle completion pulse to the owning requester.
REQ-014 result  out  WIDTH  registered result; held until the next completion.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; encodings come from the shared package.
REQ-017 IDLE: if any req is high, the arbiter selects a winner by round-robin, registers gnt, latches the winner's op and operands, and moves to ISSUE; otherwise it stays in IDLE.
REQ-018 Round-robin: search starts at the index after the last served requester and wraps from 2 to 0; after reset the search starts at 0.
REQ-019 ISSUE lasts exactly one cycle: mul_start=1 if op=0, or div_start=1 if op=1, never both; the FSM then moves to WAIT.
REQ-020 WAIT: only the done of the selected unit is honoured; on it the arbiter captures the matching result into result and moves to RESP. A done from the other unit is ignored.
REQ-021 RESP lasts one cycle: done[owner]=1; then gnt clears, the served index is recorded and the FSM returns to IDLE.
REQ-022 Latency from req high in IDLE to done pulse = unit latency + 3 cycles (arbitrate, issue, RESP).
REQ-023 unit_a/unit_b come from the latched copies and stay stable from ISSUE through RESP, independent of requester inputs.
REQ-024 If req[owner] drops mid-operation, the operation still completes and done is still pulsed; no abort.
REQ-025 If req[owner] is still high in the IDLE cycle after RESP, it is treated as a new request, at lowest priority.
REQ-026 Requests arriving during ISSUE/WAIT/RESP are not lost: they are sampled as levels in the next IDLE.
REQ-027 A unit done pulse in IDLE or ISSUE is ignored and does not change result.
REQ-028 No arithmetic in this block; result is passed through unmodified at WIDTH bits.

Reset
REQ-029 When rst=1 at a clock edge, the FSM goes to IDLE and the last-served pointer is set to 2, so requester 0 is searched first.
REQ-030 When rst=1 at a clock edge, gnt, done, mul_start, div_start and busy go to 0, and result, unit_a and unit_b go to 0.
REQ-031 Reset mid-WAIT abandons the operation with no done pulse; a later stray unit done is ignored per REQ-027.

Structure
REQ-032 Package ode_arith_pkg holds the FSM state typedef, the op codes OP_MUL/OP_DIV, NREQ and the default WIDTH.
REQ-033 Sub-module rr_picker (combinational; inputs req and last-served index; output one-hot winner) is instantiated once.

Verification
REQ-034 Scenario 1, single multiply: req=001, op=0, a=6, b=7; unit done 4 cycles after start with 42 -> one mul_start, done=001 with result=42, busy low after RESP.
REQ-035 Scenario 2, all three requesting from reset: req=111 held -> grants in order 001, 010, 100, then 001 again; no requester starved.
REQ-036 Scenario 3, divide: requester 1, op=1, a=100, b=4, div_result=25 -> div_start only, done=010, result=25; mul_start stays 0.
REQ-037 Scenario 4, stray done: mul_done pulsed with 99 during an owned divide -> ignored; result = div_result.
REQ-038 Scenario 5, reset mid-WAIT: rst during WAIT, then div_done -> no done pulse, gnt=000; the next request is served normally.
REQ-039 Scenario 6, requester drop: req[2] drops during WAIT -> done=100 still pulses once, then IDLE.

Source files
------------

// File: rtl/ode_arith_pkg.sv
// ode_arith_pkg: shared FSM states, op codes and sizing for the ODE step arithmetic arbiter.
package ode_arith_pkg;
  localparam int NREQ_DEF = 3;
  localparam int WIDTH_DEF = 32;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  function automatic logic [1:0] rr_idx(logic [1:0] last, int k, int n);
    return 2'((int'(last) + k) % n);
  endfunction
  function automatic logic [1:0] oh_idx(logic [2:0] oh);
    return oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/mul_div_arbiter_if.sv
// mul_div_arbiter_if: requester-side and unit-side signals of the shared mul/div arbiter.
interface mul_div_arbiter_if #(parameter int WIDTH = 32, parameter int NREQ = 3);
  logic [NREQ-1:0] req, op, gnt, done;
  logic [NREQ*WIDTH-1:0] a_flat, b_flat;
  logic mul_start, div_start, mul_done, div_done, busy;
  logic [WIDTH-1:0] unit_a, unit_b, mul_result, div_result, result;
  modport master (
    input req, op, a_flat, b_flat, mul_done, div_done, mul_result, div_result,
    output gnt, done, result, busy, mul_start, div_start, unit_a, unit_b
  );
  modport slave (
    output req, op, a_flat, b_flat, mul_done, div_done, mul_result, div_result,
    input gnt, done, result, busy, mul_start, div_start, unit_a, unit_b
  );
endinterface

// File: rtl/mul_div_arbiter_rr_picker.sv
// rr_picker: one-hot round-robin winner, searching from the index after last.
module rr_picker import ode_arith_pkg::*; #(parameter int NREQ = NREQ_DEF) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [NREQ-1:0] win
);
  // Walk from farthest to nearest so the nearest pending requester is written last.
  always_comb begin
    win = '0;
    for (int k = NREQ; k >= 1; k--)
      if (req[rr_idx(last, k, NREQ)]) win = NREQ'(1) << rr_idx(last, k, NREQ);
  end
endmodule

// File: rtl/mul_div_arbiter.sv
// mul_div_arbiter: round-robin sharing of one multiplier and one divider among three requesters.
module mul_div_arbiter import ode_arith_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ = NREQ_DEF
) (
  input logic clk,
  input logic rst,
  mul_div_arbiter_if.master bus
);
  state_t state, state_nx;
  logic [1:0] last, widx;
  logic [NREQ-1:0] win;
  logic op_q, unit_hit;
  rr_picker #(.NREQ(NREQ)) u_pick (.req(bus.req), .last(last), .win(win));
  assign widx = oh_idx(win);
  assign unit_hit = op_q ? bus.div_done : bus.mul_done;
  assign bus.mul_start = state == ISSUE && op_q == OP_MUL;
  assign bus.div_start = state == ISSUE && op_q == OP_DIV;
  assign bus.done = state == RESP ? bus.gnt : '0;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (|bus.req ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (unit_hit ? RESP : WAIT) : IDLE;
  end
  // Last-served resets to 2 so the first search begins at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 2'd2;
      bus.gnt <= '0;
      bus.result <= '0;
      bus.unit_a <= '0;
      bus.unit_b <= '0;
      op_q <= OP_MUL;
    end else begin
      state <= state_nx;
      if (state == IDLE && |bus.req) begin
        bus.gnt <= win;
        op_q <= bus.op[widx];
        bus.unit_a <= bus.a_flat[widx*WIDTH +: WIDTH];
        bus.unit_b <= bus.b_flat[widx*WIDTH +: WIDTH];
      end
      if (state == WAIT && unit_hit) bus.result <= op_q ? bus.div_result : bus.mul_result;
      if (state == RESP) begin
        bus.gnt <= '0;
        last <= oh_idx(bus.gnt);
      end
    end
  end
endmodule
